fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch front end sitting directly upstream of the CPU decode/execute datapath. Owns the architectural PC and issues word fetches to a variable-latency instruction memory using a req/ack handshake. Holds the fetched word stable for the CPU until the CPU signals completion. Then commits the CPU-computed next PC, and detects halt words, misaligned targets and bus timeouts.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)
TIMEOUT, 16, max cycles in FETCH without mem_ack before bus fault (legal range 2..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
next_pc  in  32  next PC computed by the CPU for the current instruction
step  in  1  CPU finished current instruction; commit next_pc (sampled only in EXEC)
mem_req  out  1  fetch request to instruction memory
mem_addr  out  30  word address, equals pc[31:2]
mem_ack  in  1  memory returns mem_rdata this cycle
mem_rdata  in  32  fetched instruction word
instr  out  32  latched instruction presented to the CPU
instr_valid  out  1  instr is valid and stable
pc  out  32  address of the current/being-fetched instruction
halted  out  1  sticky: halt word (32'h0) fetched
fault  out  1  sticky: fetch fault
fault_code  out  2  01 misaligned next_pc, 10 fetch timeout, 00 none
retired  out  32  count of committed steps

Behaviour:
- One clock (clk); reset synchronous active-high (rst). Polarity and synchronicity are fixed.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, mem_req=0, halted=0, fault=0, fault_code=00, retired=0, timeout counter=0, state=IDLE.
- Consumers must qualify instr with instr_valid; instr=0 while invalid does not mean halt.
- States: IDLE, FETCH, EXEC, HALT, FAULT.
- IDLE: one cycle after reset, then -> FETCH.
- FETCH:
  - mem_req=1 and mem_addr=pc[31:2], decoded from state, held stable until ack.
  - On mem_ack: instr<=mem_rdata and counter cleared.
    - If mem_rdata==0: -> HALT.
    - Else: -> EXEC.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 without ack: -> FAULT, fault_code<=10.
  - An ack on the same cycle as the timeout limit wins; no fault.
- EXEC:
  - instr_valid=1, mem_req=0, instr and pc frozen.
  - On step with next_pc[1:0]==00: pc<=next_pc, retired<=retired+1 (wraps mod 2^32), -> FETCH. instr_valid drops the following cycle.
  - On step with next_pc[1:0]!=00: -> FAULT, fault_code<=01. pc is not updated and retired is not incremented.
- HALT: instr_valid=1, instr=0, halted=1, mem_req=0. Sticky until rst; step is ignored.
- FAULT: fault=1, instr_valid=0, mem_req=0, pc holds the offending instruction's PC. Sticky until rst.
- mem_ack outside FETCH is ignored. step outside EXEC is ignored.
- Latency: zero-wait memory (ack in the first FETCH cycle) gives instr_valid the next cycle. Best-case throughput is one instruction per 2 cycles plus the CPU's EXEC dwell.
- Reset mid-fetch: mem_req deasserts after the reset edge. A late ack arriving in IDLE is discarded.
- The fault and halt conditions cannot both occur in one cycle (they are evaluated in different states).

Test Plan:
- Reset with RESET_PC=0; memory acks the first cycle with 32'h2008_0005 -> mem_addr=0 in FETCH, instr_valid=1 with instr=32'h2008_0005 one cycle later; pc=0, retired=0.
- In EXEC, pulse step with next_pc=32'h0000_0004 -> pc=4, mem_addr=1, retired=1. Holding step high in HALT/FETCH does not increment retired.
- Memory acks after 5 wait cycles with TIMEOUT=16 -> mem_req stays high for 6 cycles, then instr is latched with no fault. With the ack withheld for 16 cycles -> fault=1, fault_code=10, mem_req=0.
- step with next_pc=32'h0000_0006 -> fault=1, fault_code=01, pc unchanged, retired unchanged.
- Fetch returns 32'h0000_0000 -> halted=1, instr_valid=1, no further mem_req across 20 cycles and subsequent steps.
- Assert rst during a pending fetch at pc=0x40 -> the next cycle shows mem_req=0, pc=RESET_PC. An ack arriving in IDLE is ignored, and a fresh fetch from RESET_PC follows.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch front end. Owns the architectural PC, issues word fetches to a
// variable-latency instruction memory over a req/ack handshake, presents the fetched word to
// the CPU until it signals completion, then commits the CPU-computed next PC. Detects halt
// words (32'h0), misaligned branch targets and fetch timeouts.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         synchronous active-high reset
//   next_pc     next PC from the CPU for the current instruction
//   step        CPU finished current instruction (only looked at in EXEC)
//   mem_req     fetch request to instruction memory
//   mem_addr    word address of the fetch (pc[31:2])
//   mem_ack     memory returns mem_rdata this cycle (only looked at in FETCH)
//   mem_rdata   fetched instruction word
//   instr       latched instruction presented to the CPU
//   instr_valid instr is valid and stable
//   pc          address of the current / being-fetched instruction
//   halted      sticky, halt word fetched
//   fault       sticky, fetch fault
//   fault_code  01 misaligned next_pc, 10 fetch timeout, 00 none
//   retired     count of committed steps (wraps)
// ---------------------------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_pc,
   input  logic        step,
   output logic        mem_req,
   output logic [29:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {StIdle, StFetch, StExec, StHalt, StFault} state_e;

   // Last counter value at which an ack is still accepted; no ack there means timeout.
   localparam logic [7:0] CountLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retired_q, retired_d;
   logic [1:0]  fault_code_q, fault_code_d;
   logic [7:0]  count_q, count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         instr_q      <= 32'h0;
         retired_q    <= 32'h0;
         fault_code_q <= 2'b00;
         count_q      <= 8'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         retired_q    <= retired_d;
         fault_code_q <= fault_code_d;
         count_q      <= count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      retired_d    = retired_q;
      fault_code_d = fault_code_q;
      count_d      = count_q;

      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
            count_d = 8'h0;
         end
         StFetch: begin
            if (mem_ack) begin
               // Ack wins over a simultaneous timeout.
               instr_d = mem_rdata;
               count_d = 8'h0;
               state_d = (mem_rdata == 32'h0) ? StHalt : StExec;
            end else if (count_q == CountLast) begin
               count_d      = 8'h0;
               fault_code_d = 2'b10;
               state_d      = StFault;
            end else begin
               count_d = count_q + 8'd1;
            end
         end
         StExec: begin
            if (step) begin
               if (next_pc[1:0] == 2'b00) begin
                  pc_d      = next_pc;
                  retired_d = retired_q + 32'd1;
                  state_d   = StFetch;
               end else begin
                  // pc keeps pointing at the instruction that produced the bad target.
                  fault_code_d = 2'b01;
                  state_d      = StFault;
               end
            end
         end
         StHalt:  state_d = StHalt;
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase
   end

   assign mem_req     = (state_q == StFetch);
   assign mem_addr    = pc_q[31:2];
   assign instr       = instr_q;
   assign instr_valid = (state_q == StExec) || (state_q == StHalt);
   assign pc          = pc_q;
   assign halted      = (state_q == StHalt);
   assign fault       = (state_q == StFault);
   assign fault_code  = fault_code_q;
   assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. A memory responder serves each fetch after a chosen
// number of wait cycles; expected PC, retired count, request duration and sticky status are
// derived from a small architectural model (pc, retired, timeout rule) kept in the bench.
// ---------------------------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam int          TO  = 16;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] next_pc = 32'h0;
   logic        step = 1'b0;
   logic        mem_req;
   logic [29:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic        halted;
   logic        fault;
   logic [1:0]  fault_code;
   logic [31:0] retired;

   int n_total = 0;
   int n_pass  = 0;

   // Architectural model
   logic [31:0] m_pc;
   logic [31:0] m_retired;

   fetch_sequencer #(
      .RESET_PC (RPC),
      .TIMEOUT  (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .next_pc     (next_pc),
      .step        (step),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .halted      (halted),
      .fault       (fault),
      .fault_code  (fault_code),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   // Request cycles a fetch should take: ack in wait cycle w succeeds iff w < TO.
   function automatic int exp_req_cycles(input int wait_n);
      return (wait_n < TO) ? wait_n + 1 : TO;
   endfunction

   // Reset, then stop at the first FETCH cycle.
   task automatic do_reset();
      rst = 1'b1; step = 1'b0; mem_ack = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      m_pc = RPC;
      m_retired = 32'h0;
   endtask

   // Memory responder: called at the start of a FETCH; acks in cycle wait_n (0-based).
   // With noise set, step/next_pc are toggled randomly while fetching.
   task automatic serve_fetch(input int wait_n, input logic [31:0] data, input bit noise,
                              output int req_cycles, output bit addr_ok);
      req_cycles = 0;
      addr_ok    = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (!mem_req) break;
         req_cycles++;
         if (mem_addr !== m_pc[31:2]) addr_ok = 1'b0;
         mem_ack   = (i == wait_n);
         mem_rdata = (i == wait_n) ? data : $urandom;
         step      = noise ? 1'($urandom) : 1'b0;
         next_pc   = $urandom & ~32'h3;
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      step    = 1'b0;
   endtask

   task automatic do_step(input logic [31:0] npc);
      step = 1'b1; next_pc = npc;
      @(posedge clk); #1;
      step = 1'b0;
      if (npc[1:0] == 2'b00) begin
         m_pc = npc;
         m_retired = m_retired + 32'd1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if ({pc, instr, retired} !== {RPC, 32'h0, 32'h0})
         $display("FAIL reset_words: pc=%h instr=%h retired=%h want %h 0 0", pc, instr, retired,
                  RPC);
      else n_pass++;
      n_total++;
      if ({instr_valid, mem_req, halted, fault, fault_code} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000",
                  {instr_valid, mem_req, halted, fault, fault_code});
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
      n_total++;
      if (mem_req !== 1'b1 || mem_addr !== RPC[31:2])
         $display("FAIL idle_to_fetch: mem_req=%b addr=%h want 1 %h", mem_req, mem_addr,
                  RPC[31:2]);
      else n_pass++;
      m_pc = RPC;
      m_retired = 32'h0;
   endtask

   task automatic test_first_fetch_and_step();
      int rc; bit ok;
      serve_fetch(0, 32'h2008_0005, 1'b1, rc, ok);
      n_total++;
      if (rc !== 1 || !ok) $display("FAIL zero_wait_req: cycles=%0d addr_ok=%0d want 1 1", rc, ok);
      else n_pass++;
      n_total++;
      if (instr_valid !== 1'b1 || instr !== 32'h2008_0005)
         $display("FAIL zero_wait_instr: valid=%b instr=%h want 1 20080005", instr_valid, instr);
      else n_pass++;
      n_total++;
      if (pc !== 32'h0 || retired !== 32'h0)
         $display("FAIL first_exec_pc: pc=%h retired=%0d want 0 0", pc, retired);
      else n_pass++;
      do_step(32'h0000_0004);
      n_total++;
      if (pc !== 32'h4 || mem_addr !== 30'h1 || retired !== 32'd1 || instr_valid !== 1'b0)
         $display("FAIL step_commit: pc=%h addr=%h retired=%0d valid=%b want 4 1 1 0", pc,
                  mem_addr, retired, instr_valid);
      else n_pass++;
   endtask

   task automatic test_wait_and_timeout();
      int rc; bit ok;
      serve_fetch(5, 32'h1234_5678, 1'b1, rc, ok);
      n_total++;
      if (rc !== exp_req_cycles(5) || fault !== 1'b0 || instr !== 32'h1234_5678)
         $display("FAIL wait5: cycles=%0d fault=%b instr=%h want %0d 0 12345678", rc, fault,
                  instr, exp_req_cycles(5));
      else n_pass++;
      do_step(32'h0000_0008);
      serve_fetch(TO - 1, 32'hCAFE_0001, 1'b0, rc, ok);
      n_total++;
      if (rc !== TO || fault !== 1'b0 || instr_valid !== 1'b1 || instr !== 32'hCAFE_0001)
         $display("FAIL ack_at_limit: cycles=%0d fault=%b valid=%b instr=%h want %0d 0 1 cafe0001",
                  rc, fault, instr_valid, instr, TO);
      else n_pass++;
      do_step(32'h0000_000C);
      serve_fetch(1000, 32'h1, 1'b0, rc, ok);
      n_total++;
      if (rc !== exp_req_cycles(1000) || fault !== 1'b1 || fault_code !== 2'b10 ||
          mem_req !== 1'b0 || pc !== m_pc || retired !== m_retired)
         $display("FAIL timeout: cycles=%0d fault=%b code=%b req=%b pc=%h ret=%0d want %0d 1 10 0 %h %0d",
                  rc, fault, fault_code, mem_req, pc, retired, exp_req_cycles(1000), m_pc,
                  m_retired);
      else n_pass++;
   endtask

   task automatic test_misaligned();
      int rc; bit ok; bit sticky;
      do_reset();
      serve_fetch(2, 32'h0000_0013, 1'b0, rc, ok);
      do_step(32'h0000_0004);
      serve_fetch(0, 32'h0000_0093, 1'b0, rc, ok);
      do_step(32'h0000_0006);
      n_total++;
      if (fault !== 1'b1 || fault_code !== 2'b01 || pc !== 32'h4 || retired !== 32'd1 ||
          instr_valid !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL misaligned: fault=%b code=%b pc=%h ret=%0d valid=%b req=%b want 1 01 4 1 0 0",
                  fault, fault_code, pc, retired, instr_valid, mem_req);
      else n_pass++;
      sticky = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step = 1'b1; next_pc = $urandom & ~32'h3; mem_ack = 1'($urandom);
         @(posedge clk); #1;
         if (fault !== 1'b1 || mem_req !== 1'b0 || pc !== 32'h4 || retired !== 32'd1)
            sticky = 1'b0;
      end
      step = 1'b0; mem_ack = 1'b0;
      n_total++;
      if (!sticky) $display("FAIL fault_sticky: got 0 want 1");
      else n_pass++;
   endtask

   task automatic test_halt();
      int rc; bit ok; bit quiet;
      do_reset();
      serve_fetch(3, 32'h0000_0000, 1'b0, rc, ok);
      n_total++;
      if (halted !== 1'b1 || instr_valid !== 1'b1 || instr !== 32'h0 || fault !== 1'b0)
         $display("FAIL halt_entry: halted=%b valid=%b instr=%h fault=%b want 1 1 0 0", halted,
                  instr_valid, instr, fault);
      else n_pass++;
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step = 1'($urandom); next_pc = $urandom & ~32'h3;
         mem_ack = 1'($urandom); mem_rdata = $urandom;
         @(posedge clk); #1;
         if (mem_req !== 1'b0 || halted !== 1'b1 || retired !== 32'h0 || pc !== RPC)
            quiet = 1'b0;
      end
      step = 1'b0; mem_ack = 1'b0;
      n_total++;
      if (!quiet) $display("FAIL halt_sticky: got 0 want 1");
      else n_pass++;
   endtask

   task automatic test_reset_mid_fetch();
      int rc; bit ok;
      do_reset();
      serve_fetch(0, 32'h0000_0033, 1'b0, rc, ok);
      do_step(32'h0000_0040);
      n_total++;
      if (mem_req !== 1'b1 || mem_addr !== 30'h10)
         $display("FAIL fetch_at_40: req=%b addr=%h want 1 10", mem_req, mem_addr);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (mem_req !== 1'b0 || pc !== RPC)
         $display("FAIL reset_mid_fetch: req=%b pc=%h want 0 %h", mem_req, pc, RPC);
      else n_pass++;
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      m_pc = RPC; m_retired = 32'h0;
      n_total++;
      if (mem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0 || mem_addr !== RPC[31:2])
         $display("FAIL late_ack_ignored: req=%b valid=%b instr=%h addr=%h want 1 0 0 %h",
                  mem_req, instr_valid, instr, mem_addr, RPC[31:2]);
      else n_pass++;
      serve_fetch(2, 32'h0BAD_F00D, 1'b0, rc, ok);
      n_total++;
      if (rc !== 3 || !ok || instr !== 32'h0BAD_F00D || instr_valid !== 1'b1)
         $display("FAIL refetch: cycles=%0d addr_ok=%0d instr=%h valid=%b want 3 1 0badf00d 1",
                  rc, ok, instr, instr_valid);
      else n_pass++;
   endtask

   task automatic test_random();
      int rc; bit ok; bit stable; int w; int dwell;
      logic [31:0] data; logic [31:0] npc;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         w = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, TO - 1);
         data = $urandom;
         if (data == 32'h0) data = 32'h1;
         serve_fetch(w, data, 1'b1, rc, ok);
         n_total++;
         if (rc !== exp_req_cycles(w) || !ok)
            $display("FAIL rnd_req[%0d]: cycles=%0d addr_ok=%0d want %0d 1", n, rc, ok,
                     exp_req_cycles(w));
         else n_pass++;
         n_total++;
         if (instr !== data || instr_valid !== 1'b1 || pc !== m_pc)
            $display("FAIL rnd_exec[%0d]: instr=%h valid=%b pc=%h want %h 1 %h", n, instr,
                     instr_valid, pc, data, m_pc);
         else n_pass++;
         dwell = $urandom_range(0, 3);
         stable = 1'b1;
         for (int d = 0; d < dwell; d++) begin
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            @(posedge clk); #1;
            if (instr !== data || instr_valid !== 1'b1 || mem_req !== 1'b0) stable = 1'b0;
         end
         mem_ack = 1'b0;
         n_total++;
         if (!stable) $display("FAIL rnd_stable[%0d]: got 0 want 1", n);
         else n_pass++;
         npc = $urandom & ~32'h3;
         do_step(npc);
         n_total++;
         if (pc !== m_pc || retired !== m_retired || fault !== 1'b0)
            $display("FAIL rnd_commit[%0d]: pc=%h ret=%0d fault=%b want %h %0d 0", n, pc,
                     retired, fault, m_pc, m_retired);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_first_fetch_and_step();
      test_wait_and_timeout();
      test_misaligned();
      test_halt();
      test_reset_mid_fetch();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
